// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered active-low domain reset release (clk, rst, req_rst, dom_ack in; rstn_out, busy, done, err, err_dom out)
module reset_sequencer #(
  parameter int NUM_DOM     = 4,
  parameter int HOLD_CYC    = 16,
  parameter int STEP_CYC    = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_rst,
  input  logic [NUM_DOM-1:0] dom_ack,
  output logic [NUM_DOM-1:0] rstn_out,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [3:0]         err_dom
);
  typedef enum logic [2:0] {HOLD, RELEASE, WAIT_ACK, GAP, RUN} state_t;
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_END = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_END  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0]       LAST     = 4'(NUM_DOM - 1);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       idx;
  logic [15:0]      ack_vec;
  logic             ack;
  logic             timeout;
  assign ack_vec = 16'(dom_ack);
  assign ack     = ack_vec[idx];
  assign timeout = cnt == ACK_END;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HOLD;
      cnt      <= '0;
      idx      <= '0;
      rstn_out <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      err_dom  <= '0;
    end else if (req_rst) begin
      state    <= HOLD;
      cnt      <= '0;
      idx      <= '0;
      rstn_out <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          cnt   <= cnt == HOLD_END ? '0 : cnt + 1'b1;
          state <= cnt == HOLD_END ? RELEASE : HOLD;
        end
        RELEASE: begin
          rstn_out <= rstn_out | (NUM_DOM'(1) << idx);
          cnt      <= '0;
          state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack || timeout) begin
            // a timeout is logged, then the sequence moves on as if acked
            if (!ack) begin
              err     <= 1'b1;
              err_dom <= idx;
            end
            cnt <= '0;
            if (idx == LAST) begin
              state    <= RUN;
              rstn_out <= '1;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == STEP_END) begin
            cnt   <= '0;
            idx   <= idx + 1'b1;
            state <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: state <= RUN;
        default: state <= HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed stimulus with an event-time reference model checked every cycle
module tb_reset_sequencer;
  localparam int NUM_DOM = 4, HOLD_CYC = 16, STEP_CYC = 8, ACK_TIMEOUT = 64, CNT_W = 8;
  logic clk = 1'b0, rst = 1'b1, req_rst = 1'b0;
  logic [NUM_DOM-1:0] dom_ack = '1;
  logic [NUM_DOM-1:0] rstn_out;
  logic busy, done, err;
  logic [3:0] err_dom;
  int total = 0, bad = 0;
  reset_sequencer #(.NUM_DOM(NUM_DOM), .HOLD_CYC(HOLD_CYC), .STEP_CYC(STEP_CYC),
    .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_rst(req_rst), .dom_ack(dom_ack), .rstn_out(rstn_out),
    .busy(busy), .done(done), .err(err), .err_dom(err_dom));
  always #5 clk = ~clk;
  // reference model: tracks the edge at which the next release is due and the deadline of the awaited domain
  int n = 0, next_rise = -1, k = 0, deadline = 0;
  bit awaiting = 0, m_valid = 0, m_done = 0, m_err = 0;
  logic [NUM_DOM-1:0] m_rstn = '0;
  logic [3:0] m_err_dom = '0;
  always @(posedge clk) begin
    n++;
    if (rst) begin
      m_err = 0;
      m_err_dom = '0;
      m_valid = 1;
    end
    if (rst || req_rst) begin
      m_rstn = '0;
      m_done = 0;
      k = 0;
      awaiting = 0;
      next_rise = n + HOLD_CYC + 1;
    end else if (n == next_rise) begin
      m_rstn[k] = 1'b1;
      awaiting = 1;
      deadline = n + ACK_TIMEOUT;
    end else if (awaiting && (dom_ack[k] || n == deadline)) begin
      if (!dom_ack[k]) begin
        m_err = 1;
        m_err_dom = 4'(k);
      end
      awaiting = 0;
      if (k == NUM_DOM - 1) m_done = 1;
      else begin
        k++;
        next_rise = n + STEP_CYC + 1;
      end
    end
  end
  always @(negedge clk) begin
    if (m_valid) begin
      total++;
      if ({rstn_out, busy, done, err, err_dom} !== {m_rstn, !m_done, m_done, m_err, m_err_dom}) begin
        bad++;
        $display("FAIL cycle_check n=%0d got rstn=%b busy=%b done=%b err=%b err_dom=%0d want rstn=%b busy=%b done=%b err=%b err_dom=%0d",
          n, rstn_out, busy, done, err, err_dom, m_rstn, !m_done, m_done, m_err, m_err_dom);
      end
    end
  end
  int rise_at[NUM_DOM];
  int err_at = -1, done_at = -1;
  logic [NUM_DOM-1:0] prev_rstn = '0;
  logic prev_err = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    for (int b = 0; b < NUM_DOM; b++)
      if (rstn_out[b] === 1'b1 && prev_rstn[b] !== 1'b1) rise_at[b] = n;
    if (err === 1'b1 && prev_err !== 1'b1) err_at = n;
    if (done === 1'b1 && prev_done !== 1'b1) done_at = n;
    prev_rstn = rstn_out;
    prev_err = err;
    prev_done = done;
  end
  task automatic clear_rec();
    for (int b = 0; b < NUM_DOM; b++) rise_at[b] = -1;
    err_at = -1;
    done_at = -1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  int base;
  initial begin
    clear_rec();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = n;
    chk("t1_reset_rstn", int'(rstn_out), 0);
    chk("t1_reset_busy", int'(busy), 1);
    repeat (60) @(negedge clk);
    chk("t1_rise0", rise_at[0] - base, 17);
    chk("t1_rise1", rise_at[1] - base, 27);
    chk("t1_rise2", rise_at[2] - base, 37);
    chk("t1_rise3", rise_at[3] - base, 47);
    chk("t1_done", done_at - base, 48);
    chk("t1_err", int'(err), 0);
    req_rst = 1'b1;
    dom_ack = 4'b1011;
    @(negedge clk);
    chk("t2_rstn_drop", int'(rstn_out), 0);
    chk("t2_busy", int'(busy), 1);
    chk("t2_done", int'(done), 0);
    repeat (4) @(negedge clk);
    req_rst = 1'b0;
    base = n;
    clear_rec();
    repeat (130) @(negedge clk);
    chk("t2_rise0", rise_at[0] - base, 17);
    chk("t3_err_delay", err_at - rise_at[2], 64);
    chk("t3_err_dom", int'(err_dom), 2);
    chk("t3_rise3_after_err", rise_at[3] - err_at, 9);
    chk("t3_done", int'(done), 1);
    dom_ack = 4'b1101;
    req_rst = 1'b1;
    @(negedge clk);
    req_rst = 1'b0;
    base = n;
    clear_rec();
    repeat (32) @(negedge clk);
    chk("t4_rise1", rise_at[1] - base, 27);
    req_rst = 1'b1;
    @(negedge clk);
    req_rst = 1'b0;
    base = n;
    chk("t4_rstn_drop", int'(rstn_out), 0);
    chk("t4_err_kept", int'(err), 1);
    chk("t4_err_dom_kept", int'(err_dom), 2);
    dom_ack = '1;
    clear_rec();
    repeat (20) @(negedge clk);
    chk("t4_restart_rise0", rise_at[0] - base, 17);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_err_cleared", int'(err), 0);
    chk("t4_err_dom_cleared", int'(err_dom), 0);
    clear_rec();
    for (int i = 0; i < 5; i++) begin
      repeat (9) @(negedge clk);
      req_rst = 1'b1;
      @(negedge clk);
      req_rst = 1'b0;
    end
    base = n;
    chk("t5_no_release", int'(rstn_out), 0);
    chk("t5_no_rise", rise_at[0], -1);
    repeat (20) @(negedge clk);
    chk("t5_rise0", rise_at[0] - base, 17);
    dom_ack = 4'b1110;
    req_rst = 1'b1;
    @(negedge clk);
    req_rst = 1'b0;
    base = n;
    clear_rec();
    repeat (120) @(negedge clk);
    chk("t6_rise0", rise_at[0] - base, 17);
    chk("t6_err_delay", err_at - rise_at[0], 64);
    chk("t6_err_dom", int'(err_dom), 0);
    chk("t6_rise1", rise_at[1] - base, 90);
    chk("t6_rise2", rise_at[2] - base, 100);
    chk("t6_rise3", rise_at[3] - base, 110);
    chk("t6_done", done_at - base, 111);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
